// File: rtl/dcache_mem_arbiter.sv
// Round-robin arbiter sharing the dcache tag/data port among NR_PORTS requesters, with owner lock.
// Define DCACHE_ARB_STARVE_GUARD_EN to add per-port wait counters that override round-robin.
module dcache_mem_arbiter #(
   parameter int NR_PORTS   = 3,
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 128,
   parameter int MAX_WAIT   = 15
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [NR_PORTS-1:0]            req_i,
   input  logic [NR_PORTS-1:0]            lock_i,
   input  logic [NR_PORTS-1:0]            we_i,
   input  logic [NR_PORTS*ADDR_WIDTH-1:0] addr_i,
   input  logic [NR_PORTS*DATA_WIDTH-1:0] wdata_i,
   output logic [NR_PORTS-1:0]            gnt_o,
   output logic [NR_PORTS-1:0]            rvalid_o,
   input  logic                           mem_ready_i,
   output logic                           mem_req_o,
   output logic                           mem_we_o,
   output logic [ADDR_WIDTH-1:0]          mem_addr_o,
   output logic [DATA_WIDTH-1:0]          mem_wdata_o,
   output logic                           lock_active_o,
   output logic [NR_PORTS-1:0]            starve_o
);

   // Handshake: a port's request is accepted in the cycle gnt_o[i]=1 (same cycle as
   // req_i[i]); mem_req_o marks that access, and a read answers with rvalid_o[i] exactly
   // one cycle later. Nothing is granted while mem_ready_i=0 or rst_i=1.

   localparam int PTR_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

   typedef enum logic {
      LOCK_IDLE = 1'b0,
      LOCK_HELD = 1'b1
   } lock_state_e;

   lock_state_e           lock_q, lock_d;
   logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]      owner_q, owner_d;
   logic [NR_PORTS-1:0]   id_q, id_d;
   logic [PTR_W-1:0]      winner;
   logic [PTR_W-1:0]      scan_idx;
   logic                  gnt_valid;
   logic                  arb_en;
   logic [NR_PORTS-1:0]   gnt;
   logic [NR_PORTS-1:0]   starve;

   assign arb_en = mem_ready_i & ~rst_i;

`ifdef DCACHE_ARB_STARVE_GUARD_EN
   localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

   logic [CNT_W-1:0] wait_cnt_q [NR_PORTS];

   for (genvar i = 0; i < NR_PORTS; i++) begin : g_wait_cnt
      // Counts cycles a port was ready to go but lost; saturates at MAX_WAIT.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            wait_cnt_q[i] <= '0;
         end else if (!req_i[i] || gnt[i]) begin
            wait_cnt_q[i] <= '0;
         end else if (mem_ready_i && (wait_cnt_q[i] != CNT_W'(MAX_WAIT))) begin
            wait_cnt_q[i] <= wait_cnt_q[i] + 1'b1;
         end
      end
      assign starve[i] = (wait_cnt_q[i] == CNT_W'(MAX_WAIT));
   end
`else
   logic unused_max_wait;
   assign unused_max_wait = ^MAX_WAIT;
   assign starve          = '0;
`endif

   // Arbitration and lock/pointer next state.
   always_comb begin
      winner    = '0;
      scan_idx  = '0;
      gnt_valid = 1'b0;
      rr_ptr_d  = rr_ptr_q;
      owner_d   = owner_q;
      lock_d    = lock_q;

      if (arb_en) begin
         if (lock_q == LOCK_HELD) begin
            if (req_i[owner_q]) begin
               winner    = owner_q;
               gnt_valid = 1'b1;
            end
         end else begin
            // A starving port (lowest index first) jumps the round-robin order.
            for (int i = 0; i < NR_PORTS; i++) begin
               if (!gnt_valid && starve[i] && req_i[i]) begin
                  winner    = PTR_W'(i);
                  gnt_valid = 1'b1;
               end
            end
            for (int k = 0; k < NR_PORTS; k++) begin
               scan_idx = PTR_W'((int'(rr_ptr_q) + k) % NR_PORTS);
               if (!gnt_valid && req_i[scan_idx]) begin
                  winner    = scan_idx;
                  gnt_valid = 1'b1;
               end
            end
         end
      end

      if (gnt_valid) begin
         rr_ptr_d = (winner == PTR_W'(NR_PORTS - 1)) ? '0 : winner + 1'b1;
         if (lock_i[winner]) begin
            lock_d  = LOCK_HELD;
            owner_d = winner;
         end else begin
            lock_d  = LOCK_IDLE;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NR_PORTS; i++) begin
         gnt[i] = gnt_valid && (winner == PTR_W'(i));
      end
   end

   // Writes never return data, so they never raise the response ID.
   assign id_d = gnt & ~we_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lock_q   <= LOCK_IDLE;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         id_q     <= '0;
      end else begin
         lock_q   <= lock_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         id_q     <= id_d;
      end
   end

   assign gnt_o         = gnt;
   assign rvalid_o      = id_q;
   assign mem_req_o     = |gnt;
   assign mem_we_o      = gnt_valid & we_i[winner];
   assign mem_addr_o    = gnt_valid ? addr_i[winner*ADDR_WIDTH +: ADDR_WIDTH] : '0;
   assign mem_wdata_o   = gnt_valid ? wdata_i[winner*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign lock_active_o = (lock_q == LOCK_HELD);
   assign starve_o      = starve;

`ifndef SYNTHESIS
   always @(posedge clk_i) begin
      if (!rst_i) begin
         assert ($onehot0(gnt)) else $error("gnt_o not one-hot0: %b", gnt);
         assert ($onehot0(id_q)) else $error("rvalid_o not one-hot0: %b", id_q);
      end
   end
`endif

endmodule

// File: tb/tb_dcache_mem_arbiter.sv
// Directed scoreboard bench for dcache_mem_arbiter (3 ports, MAX_WAIT=2).
module tb_dcache_mem_arbiter;

   localparam int NP = 3;
   localparam int AW = 64;
   localparam int DW = 128;
   localparam int GW = 32 + NP + 1 + AW + DW;
   localparam int RW = 32 + NP;

`ifdef DCACHE_ARB_STARVE_GUARD_EN
   localparam logic [NP-1:0] ST_EARLY = 3'b000;
   localparam logic [NP-1:0] ST_LATE  = 3'b101;
   localparam logic [NP-1:0] ST_S7    = 3'b100;
   localparam int            E6       = 0;
   localparam logic [NP-1:0] REQ7     = 3'b100;
   localparam int            E7       = 2;
`else
   localparam logic [NP-1:0] ST_EARLY = 3'b000;
   localparam logic [NP-1:0] ST_LATE  = 3'b000;
   localparam logic [NP-1:0] ST_S7    = 3'b000;
   localparam int            E6       = 2;
   localparam logic [NP-1:0] REQ7     = 3'b001;
   localparam int            E7       = 0;
`endif

   logic              clk = 1'b0;
   logic              rst_i = 1'b1;
   logic [NP-1:0]     req_i = '0;
   logic [NP-1:0]     lock_i = '0;
   logic [NP-1:0]     we_i = '0;
   logic [NP*AW-1:0]  addr_i;
   logic [NP*DW-1:0]  wdata_i;
   logic              mem_ready_i = 1'b0;
   logic [NP-1:0]     gnt_o, rvalid_o, starve_o;
   logic              mem_req_o, mem_we_o, lock_active_o;
   logic [AW-1:0]     mem_addr_o;
   logic [DW-1:0]     mem_wdata_o;

   logic [AW-1:0]     addr_v  [NP];
   logic [DW-1:0]     wdata_v [NP];

   logic [GW-1:0]     exp_q[$];
   logic [RW-1:0]     rv_q[$];
   int                checks = 0;
   int                errors = 0;
   int                cyc = 0;

   initial begin
      addr_v[0]  = 64'h0000_0000_0000_1000;
      addr_v[1]  = 64'h0000_0000_0000_2040;
      addr_v[2]  = 64'h0000_0000_0000_0080;
      wdata_v[0] = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
      wdata_v[1] = 128'hDEAD_BEEF_0000_0001_0000_0002_0000_0003;
      wdata_v[2] = 128'h0000_0000_0000_0000_0000_0000_0000_00A5;
   end

   assign addr_i  = {addr_v[2], addr_v[1], addr_v[0]};
   assign wdata_i = {wdata_v[2], wdata_v[1], wdata_v[0]};

   dcache_mem_arbiter #(
      .NR_PORTS  (NP),
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .MAX_WAIT  (2)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .req_i        (req_i),
      .lock_i       (lock_i),
      .we_i         (we_i),
      .addr_i       (addr_i),
      .wdata_i      (wdata_i),
      .gnt_o        (gnt_o),
      .rvalid_o     (rvalid_o),
      .mem_ready_i  (mem_ready_i),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .lock_active_o(lock_active_o),
      .starve_o     (starve_o)
   );

   // Clock and cycle stamp.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [GW-1:0] act, input logic [GW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drives one cycle of inputs and records the grant / read response it should produce.
   task automatic step(input logic [NP-1:0] req, input logic [NP-1:0] lock,
                       input logic [NP-1:0] we, input logic rdy,
                       input int exp_port, input bit keep_rv);
      logic [NP-1:0] g;
      @(posedge clk);
      #1;
      rst_i       = 1'b0;
      req_i       = req;
      lock_i      = lock;
      we_i        = we;
      mem_ready_i = rdy;
      if (exp_port >= 0) begin
         g = '0;
         g[exp_port] = 1'b1;
         exp_q.push_back({32'(cyc), g, we[exp_port], addr_v[exp_port], wdata_v[exp_port]});
         if (!we[exp_port] && keep_rv) rv_q.push_back({32'(cyc + 1), g});
      end
   endtask

   task automatic idle();
      step(3'b000, 3'b000, 3'b000, 1'b1, -1, 1'b1);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a grant or response.
   always @(negedge clk) begin
      if (!rst_i) begin
         if (mem_req_o) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_grant: got gnt %b at cycle %0d expected none", gnt_o, cyc);
            end else begin
               chk("grant", {32'(cyc), gnt_o, mem_we_o, mem_addr_o, mem_wdata_o}, exp_q.pop_front());
            end
         end else begin
            chk("idle_outputs", GW'({gnt_o, mem_we_o, mem_addr_o, mem_wdata_o}), '0);
         end
         if (rvalid_o != '0) begin
            if (rv_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rvalid: got %b at cycle %0d expected none", rvalid_o, cyc);
            end else begin
               chk("rvalid", GW'({32'(cyc), rvalid_o}), GW'(rv_q.pop_front()));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state.
      rst_i = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;
      @(negedge clk);
      chk("rst_gnt", GW'(gnt_o), '0);
      chk("rst_rvalid", GW'(rvalid_o), '0);
      chk("rst_lock", GW'(lock_active_o), '0);
      chk("rst_starve", GW'(starve_o), '0);
      chk("rst_mem_req", GW'(mem_req_o), '0);

      // All three ports reading: plain rotation.
      for (int i = 0; i < 6; i++) step(3'b111, 3'b000, 3'b000, 1'b1, i % 3, 1'b1);
      idle();

      // Move pointer to port1, then port1 locks for three grants and unlocks on the fourth.
      step(3'b001, 3'b000, 3'b000, 1'b1, 0, 1'b1);
      step(3'b111, 3'b010, 3'b000, 1'b1, 1, 1'b1);
      @(negedge clk) chk("lock_c0", GW'(lock_active_o), GW'(1'b0));
      step(3'b111, 3'b010, 3'b000, 1'b1, 1, 1'b1);
      @(negedge clk) chk("lock_c1", GW'(lock_active_o), GW'(1'b1));
      step(3'b111, 3'b010, 3'b000, 1'b1, 1, 1'b1);
      @(negedge clk) chk("lock_c2", GW'(lock_active_o), GW'(1'b1));
      step(3'b111, 3'b000, 3'b000, 1'b1, 1, 1'b1);
      @(negedge clk) chk("lock_c3", GW'(lock_active_o), GW'(1'b1));
      step(3'b111, 3'b000, 3'b000, 1'b1, 2, 1'b1);
      @(negedge clk) chk("lock_c4", GW'(lock_active_o), GW'(1'b0));
      idle();

      // Memory not ready: no grants, pointer held.
      step(3'b101, 3'b000, 3'b000, 1'b0, -1, 1'b1);
      @(negedge clk) chk("stall_mem_req", GW'(mem_req_o), '0);
      step(3'b101, 3'b000, 3'b000, 1'b0, -1, 1'b1);
      @(negedge clk) chk("stall_gnt", GW'(gnt_o), '0);
      step(3'b101, 3'b000, 3'b000, 1'b1, 0, 1'b1);
      step(3'b101, 3'b000, 3'b000, 1'b1, 2, 1'b1);
      idle();

      // Port2 write alone: muxed write, no response.
      step(3'b100, 3'b000, 3'b100, 1'b1, 2, 1'b1);
      @(negedge clk) chk("wr_addr", GW'(mem_addr_o), GW'(64'h80));
      idle();
      idle();
      // Mixed write/read back to back.
      step(3'b011, 3'b000, 3'b001, 1'b1, 0, 1'b1);
      step(3'b011, 3'b000, 3'b001, 1'b1, 1, 1'b1);
      idle();

      // Reset while port0 holds the lock with a read in flight.
      step(3'b001, 3'b001, 3'b000, 1'b1, 0, 1'b0);
      @(posedge clk);
      #1 rst_i = 1'b1;
      step(3'b010, 3'b000, 3'b000, 1'b1, 1, 1'b1);
      @(negedge clk);
      chk("post_rst_rvalid", GW'(rvalid_o), '0);
      chk("post_rst_lock", GW'(lock_active_o), '0);
      idle();

      // Long lock by port1 while ports 0 and 2 wait.
      step(3'b010, 3'b010, 3'b000, 1'b1, 1, 1'b1);
      step(3'b111, 3'b010, 3'b000, 1'b1, 1, 1'b1);
      @(negedge clk) chk("starve_s1", GW'(starve_o), GW'(ST_EARLY));
      step(3'b111, 3'b010, 3'b000, 1'b1, 1, 1'b1);
      @(negedge clk) chk("starve_s2", GW'(starve_o), GW'(ST_EARLY));
      step(3'b111, 3'b010, 3'b000, 1'b1, 1, 1'b1);
      @(negedge clk) chk("starve_s3", GW'(starve_o), GW'(ST_LATE));
      step(3'b111, 3'b010, 3'b000, 1'b1, 1, 1'b1);
      @(negedge clk) chk("starve_s4", GW'(starve_o), GW'(ST_LATE));
      step(3'b111, 3'b000, 3'b000, 1'b1, 1, 1'b1);
      @(negedge clk) chk("starve_s5", GW'(starve_o), GW'(ST_LATE));
      step(3'b101, 3'b000, 3'b000, 1'b1, E6, 1'b1);
      @(negedge clk) chk("starve_s6", GW'(starve_o), GW'(ST_LATE));
      step(REQ7, 3'b000, 3'b000, 1'b1, E7, 1'b1);
      @(negedge clk) chk("starve_s7", GW'(starve_o), GW'(ST_S7));
      idle();
      idle();

      @(negedge clk);
      chk("grant_queue_drained", GW'(exp_q.size()), '0);
      chk("rvalid_queue_drained", GW'(rv_q.size()), '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dcache_mem_arbiter.md
Name: dcache_mem_arbiter

Overview:
- Shares one set-associative dcache tag/data memory port among NR_PORTS requesters: miss handler, load unit, store unit.
- Fair round-robin arbitration, optional multi-cycle lock for the owner, and a one-cycle-delayed one-hot response ID so the tag compare selects the correct late tag.
- Sits between the requesters and the tag-compare/SRAM macro.

Parameters:
NR_PORTS, 3, number of requesters (>=1)
ADDR_WIDTH, 64, request address width
DATA_WIDTH, 128, write data width
MAX_WAIT, 15, starvation threshold in cycles (used only with the optional feature)

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_i  in  1  synchronous, active-high reset
req_i  in  NR_PORTS  per-port request
lock_i  in  NR_PORTS  per-port: keep ownership after this granted access
we_i  in  NR_PORTS  per-port write enable
addr_i  in  NR_PORTS*ADDR_WIDTH  per-port address
wdata_i  in  NR_PORTS*DATA_WIDTH  per-port write data
gnt_o  out  NR_PORTS  one-hot0 grant, same cycle as request
rvalid_o  out  NR_PORTS  one-hot0; read data/hit valid for this port, one cycle after grant
mem_ready_i  in  1  memory can accept an access this cycle
mem_req_o  out  1  memory access strobe
mem_we_o  out  1  selected write enable
mem_addr_o  out  ADDR_WIDTH  selected address
mem_wdata_o  out  DATA_WIDTH  selected write data
lock_active_o  out  1  a port currently holds the lock
starve_o  out  NR_PORTS  port at starvation threshold

Behaviour:
- Reset: rr_ptr_q=0, lock_q=0, owner_q=0, id_q=0, wait counters=0; gnt_o, rvalid_o, mem_req_o, starve_o, lock_active_o all 0; mem_* data outputs 0.
- Arbitration is combinational each cycle, only when mem_ready_i=1. With mem_ready_i=0: gnt_o=0, mem_req_o=0, state held.
- Unlocked: winner is the first requesting port scanning rr_ptr_q, rr_ptr_q+1, ... modulo NR_PORTS.
  - On a grant, rr_ptr_q <= (winner+1) mod NR_PORTS.
  - No request: pointer unchanged.
- Locked (lock_q=1): only owner_q may be granted; other ports get gnt_o=0. Owner idle means no access; the lock is held.
- Lock set: a granted port with lock_i=1 sets lock_q=1 and owner_q=winner.
- Lock clear: owner granted with lock_i=0 clears lock_q. That access still completes normally.
- mem_req_o=|gnt_o. mem_we_o, mem_addr_o and mem_wdata_o are muxed from the winner; all 0 when there is no grant.
- Response: id_q <= gnt_o & ~we_i every cycle (writes produce no rvalid). rvalid_o=id_q, exactly 1-cycle latency; this is the tag-select ID for the tag compare.
  - rvalid is unaffected by mem_ready_i in the response cycle.
- Back-to-back grants to different ports on consecutive cycles are legal.
- gnt_o is always one-hot0; simulation asserts this, plus rvalid_o one-hot0.
- NR_PORTS=1: port 0 is granted whenever req_i[0] & mem_ready_i; pointer stays 0.
- Reset mid-lock or mid-response: lock and pending rvalid are dropped; no rvalid in the cycle after reset deasserts.

Optional Feature:
- Macro: DCACHE_ARB_STARVE_GUARD_EN.
- Defined:
  - Per-port saturating wait counter, width $clog2(MAX_WAIT+1).
  - Increments while req_i & ~gnt_o & mem_ready_i; cleared on grant or when req_i drops.
  - starve_o[i] = (counter==MAX_WAIT).
  - Outside lock, the lowest-index starving port overrides round-robin, and rr_ptr_q updates from it as usual.
  - Lock is never broken; a starving port waits for the unlock.
- Undefined: no counters; starve_o tied 0; pure round-robin.

Test Plan:
- Reset, then req_i=3'b111 held 6 cycles, mem_ready_i=1, we=0 -> gnt_o sequence 001,010,100,001,010,100; rvalid_o repeats the same sequence one cycle later.
- Port1 req with lock_i=1 for 3 grants then lock_i=0, ports 0/2 requesting throughout -> gnt_o=010 for 4 cycles, lock_active_o=1 cycles 1-3, next grant port2.
- mem_ready_i=0 for 2 cycles with req_i=3'b101 -> gnt_o=0, mem_req_o=0, pointer unchanged; first ready cycle grants port0.
- Port2 write (we=1, addr=0x80, wdata=0xA5) alone -> mem_we_o=1, mem_addr_o=0x80, mem_wdata_o=0xA5, gnt_o=100, rvalid_o stays 0.
- Assert rst_i while port0 holds lock with a read granted -> next cycle rvalid_o=0, lock_active_o=0, then req_i=3'b010 is granted immediately.
- With DCACHE_ARB_STARVE_GUARD_EN and MAX_WAIT=2: port1 locked for 5 cycles, port0 requesting -> starve_o[0]=1 from wait cycle 2; port0 granted first after unlock ahead of the round-robin order.
